mc_controller: RTL

Multicycle control unit for the MIPS core: a state machine that sequences one shared ALU, one unified instruction/data memory port and the register file over several cycles per instruction. It decodes the opcode and funct fields from the instruction register. It drives every datapath select and write enable, and stalls on a memory ready handshake. It sits beside the multicycle datapath and replaces single-cycle combinational decode.

---
 rtl/mc_controller.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: sequences the shared ALU, unified memory port and
// register file through FETCH/DECODE/execute states, stalling on MemReady.
module mc_controller (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemToReg,
    output logic       AluSrcA,
    output logic [1:0] AluSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] AluCtl,
    output logic       ExtOp,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        IMMEX  = 4'd9,
        IMMWB  = 4'd10,
        JUMP   = 4'd11
    } stateT;

    localparam logic [5:0] opRType = 6'b000000;
    localparam logic [5:0] opLw    = 6'b100011;
    localparam logic [5:0] opSw    = 6'b101011;
    localparam logic [5:0] opBeq   = 6'b000100;
    localparam logic [5:0] opAddi  = 6'b001000;
    localparam logic [5:0] opOri   = 6'b001101;
    localparam logic [5:0] opJ     = 6'b000010;

    localparam logic [5:0] fnAdd = 6'b100000;
    localparam logic [5:0] fnSub = 6'b100010;
    localparam logic [5:0] fnAnd = 6'b100100;
    localparam logic [5:0] fnOr  = 6'b100101;
    localparam logic [5:0] fnSlt = 6'b101010;

    localparam logic [2:0] aluAnd = 3'b000;
    localparam logic [2:0] aluOr  = 3'b001;
    localparam logic [2:0] aluAdd = 3'b010;
    localparam logic [2:0] aluSub = 3'b110;
    localparam logic [2:0] aluSlt = 3'b111;

    stateT curState;
    stateT nextState;

    function automatic logic functOk(input logic [5:0] f);
        return (f == fnAdd) || (f == fnSub) || (f == fnAnd) || (f == fnOr) || (f == fnSlt);
    endfunction

    function automatic logic [2:0] aluFromFunct(input logic [5:0] f);
        case (f)
            fnSub:   return aluSub;
            fnAnd:   return aluAnd;
            fnOr:    return aluOr;
            fnSlt:   return aluSlt;
            default: return aluAdd;
        endcase
    endfunction

    always_ff @(posedge CLK) begin
        if (Reset) curState <= FETCH;
        else       curState <= nextState;
    end

    assign State = curState;

    always_comb begin
        IorD      = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        RegDst    = 1'b0;
        MemToReg  = 1'b0;
        AluSrcA   = 1'b0;
        AluSrcB   = 2'b00;
        PCSrc     = 2'b00;
        AluCtl    = 3'b000;
        ExtOp     = 1'b1;
        nextState = curState;

        case (curState)
            FETCH: begin
                MemRead = 1'b1;
                AluSrcB = 2'b01;
                AluCtl  = aluAdd;
                IRWrite = MemReady;
                PCWrite = MemReady;
                if (MemReady) nextState = DECODE;
            end
            DECODE: begin
                // Speculatively compute the branch target into ALUOut.
                AluSrcB = 2'b11;
                AluCtl  = aluAdd;
                case (Op)
                    opLw, opSw:     nextState = MEMADR;
                    opRType:        nextState = functOk(Funct) ? EXEC : FETCH;
                    opBeq:          nextState = BRANCH;
                    opAddi, opOri:  nextState = IMMEX;
                    opJ:            nextState = JUMP;
                    default:        nextState = FETCH;
                endcase
            end
            MEMADR: begin
                AluSrcA   = 1'b1;
                AluSrcB   = 2'b10;
                AluCtl    = aluAdd;
                nextState = (Op == opLw) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                if (MemReady) nextState = MEMWB;
            end
            MEMWB: begin
                MemToReg  = 1'b1;
                RegWrite  = 1'b1;
                nextState = FETCH;
            end
            MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                if (MemReady) nextState = FETCH;
            end
            EXEC: begin
                AluSrcA   = 1'b1;
                AluCtl    = aluFromFunct(Funct);
                nextState = ALUWB;
            end
            ALUWB: begin
                RegDst    = 1'b1;
                RegWrite  = 1'b1;
                nextState = FETCH;
            end
            BRANCH: begin
                AluSrcA   = 1'b1;
                AluCtl    = aluSub;
                PCSrc     = 2'b01;
                PCWrite   = Zero;
                nextState = FETCH;
            end
            IMMEX: begin
                AluSrcA   = 1'b1;
                AluSrcB   = 2'b10;
                if (Op == opOri) begin
                    AluCtl = aluOr;
                    ExtOp  = 1'b0;
                end else begin
                    AluCtl = aluAdd;
                end
                nextState = IMMWB;
            end
            IMMWB: begin
                RegWrite  = 1'b1;
                nextState = FETCH;
            end
            JUMP: begin
                PCSrc     = 2'b10;
                PCWrite   = 1'b1;
                nextState = FETCH;
            end
            default: nextState = FETCH;
        endcase

        // During reset every strobe is suppressed and datapath selects look like FETCH.
        if (Reset) begin
            IorD     = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            RegWrite = 1'b0;
            RegDst   = 1'b0;
            MemToReg = 1'b0;
            AluSrcA  = 1'b0;
            AluSrcB  = 2'b01;
            PCSrc    = 2'b00;
            AluCtl   = aluAdd;
            ExtOp    = 1'b1;
        end
    end

endmodule
